// File: rtl/lane_clk_enable_gen_pkg.sv
// Shared mode/state types and phase-increment constants for lane_clk_enable_gen.
// Increments are derived from the accumulator width so that any ACC_W keeps the same rates.
package lane_clk_enable_gen_pkg;

    typedef enum logic [1:0] {
        GEN2 = 2'd0,
        GEN3 = 2'd1,
        GEN4 = 2'd2,
        PROG = 2'd3
    } gen_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_e;

    // FSM-rate increments are tabulated at 24 bits and rescaled to the actual width.
    localparam int          REF_W            = 24;
    localparam logic [63:0] FSM_INC_GEN2_REF = 64'd2033603;
    localparam logic [63:0] FSM_INC_GEN3_REF = 64'd4067206;

    function automatic logic [63:0] scale_ref(input logic [63:0] v, input int acc_w);
        if (acc_w >= REF_W) begin
            return v << (acc_w - REF_W);
        end
        return v >> (REF_W - acc_w);
    endfunction

    // Lane rate: one strobe every 8 / 4 / 2 cycles.
    function automatic logic [63:0] lane_inc(input gen_e g, input int acc_w);
        case (g)
            GEN2:    return 64'd1 << (acc_w - 3);
            GEN3:    return 64'd1 << (acc_w - 2);
            default: return 64'd1 << (acc_w - 1);
        endcase
    endfunction

    // Symbol rate: lane rate scaled by 64/66 for the 128b/130b-less generations.
    function automatic logic [63:0] fsm_inc(input gen_e g, input int acc_w);
        case (g)
            GEN2:    return scale_ref(FSM_INC_GEN2_REF, acc_w);
            GEN3:    return scale_ref(FSM_INC_GEN3_REF, acc_w);
            default: return 64'd1 << (acc_w - 1);
        endcase
    endfunction

endpackage

// File: rtl/lane_clk_enable_gen_phase_acc.sv
// Phase accumulator with registered carry-out strobe; clear and hold both force
// the accumulator and strobe to zero for the next cycle.
module phase_acc
    import lane_clk_enable_gen_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] inc,
    input  logic             clear,
    input  logic             hold,
    output logic             stb
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             stb_q;
    logic             stb_d;

    always_comb begin
        // NOTE: defaults first so every path assigns acc_d/stb_d and no latch is inferred.
        acc_d = '0;
        stb_d = 1'b0;
        if (!(clear || hold)) begin
            {stb_d, acc_d} = {1'b0, acc_q} + {1'b0, inc};
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            stb_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            stb_q <= stb_d;
        end
    end

    assign stb = stb_q;

endmodule

// File: rtl/lane_clk_enable_gen.sv
// Lane/symbol clock-enable generator: NUM_CH lane accumulators plus one FSM-rate
// accumulator, with a glitch-free mode switch aligned to an fsm_stb. Macro: PROG_INC_EN.
module lane_clk_enable_gen
    import lane_clk_enable_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 24
) (
    input  logic              local_clk,
    input  logic              rst,
    input  logic [1:0]        gen_sel,
    input  logic              sel_req,
    output logic              sel_ack,
    output logic              sel_busy,
    input  logic [NUM_CH-1:0] lane_disable,
`ifdef PROG_INC_EN
    input  logic [ACC_W-1:0]  prog_inc,
`endif
    output logic [NUM_CH-1:0] lane_stb,
    output logic              fsm_stb,
    output logic [1:0]        cur_gen
);

    localparam logic [ACC_W-1:0] LANE_INC_GEN2 = ACC_W'(lane_inc(GEN2, ACC_W));
    localparam logic [ACC_W-1:0] LANE_INC_GEN3 = ACC_W'(lane_inc(GEN3, ACC_W));
    localparam logic [ACC_W-1:0] LANE_INC_GEN4 = ACC_W'(lane_inc(GEN4, ACC_W));
    localparam logic [ACC_W-1:0] FSM_INC_GEN2  = ACC_W'(fsm_inc(GEN2, ACC_W));
    localparam logic [ACC_W-1:0] FSM_INC_GEN3  = ACC_W'(fsm_inc(GEN3, ACC_W));
    localparam logic [ACC_W-1:0] FSM_INC_GEN4  = ACC_W'(fsm_inc(GEN4, ACC_W));

    state_e           state_q,    state_d;
    gen_e             cur_gen_q,  cur_gen_d;
    gen_e             pend_gen_q, pend_gen_d;
    logic             sel_ack_q,  sel_ack_d;
    logic             sel_busy_q, sel_busy_d;

    gen_e             req_gen;
    logic [ACC_W-1:0] lane_inc_w;
    logic [ACC_W-1:0] fsm_inc_w;
    logic             fsm_stb_w;
    logic             apply_now;

    always_comb begin
`ifdef PROG_INC_EN
        req_gen = gen_e'(gen_sel);
`else
        req_gen = (gen_sel == 2'd3) ? GEN4 : gen_e'(gen_sel);
`endif
    end

    always_comb begin
        lane_inc_w = LANE_INC_GEN4;
        fsm_inc_w  = FSM_INC_GEN4;
        unique case (cur_gen_q)
            GEN2: begin
                lane_inc_w = LANE_INC_GEN2;
                fsm_inc_w  = FSM_INC_GEN2;
            end
            GEN3: begin
                lane_inc_w = LANE_INC_GEN3;
                fsm_inc_w  = FSM_INC_GEN3;
            end
            GEN4: begin
                lane_inc_w = LANE_INC_GEN4;
                fsm_inc_w  = FSM_INC_GEN4;
            end
            PROG: begin
`ifdef PROG_INC_EN
                lane_inc_w = prog_inc;
                fsm_inc_w  = prog_inc;
`else
                lane_inc_w = LANE_INC_GEN4;
                fsm_inc_w  = FSM_INC_GEN4;
`endif
            end
        endcase
    end

    // A stopped FSM accumulator never strobes, so a switch away from it applies at once.
    assign apply_now = (state_q == PEND) && (fsm_stb_w || (fsm_inc_w == '0));

    always_comb begin
        state_d    = state_q;
        cur_gen_d  = cur_gen_q;
        pend_gen_d = pend_gen_q;
        sel_ack_d  = 1'b0;
        sel_busy_d = sel_busy_q;
        unique case (state_q)
            PEND: begin
                if (apply_now) begin
                    state_d    = APPLY;
                    cur_gen_d  = pend_gen_q;
                    sel_ack_d  = 1'b1;
                    sel_busy_d = 1'b0;
                end
            end
            IDLE, APPLY: begin
                state_d    = IDLE;
                sel_busy_d = 1'b0;
                if (sel_req) begin
                    if (req_gen == cur_gen_q) begin
                        sel_ack_d = 1'b1;
                    end else begin
                        pend_gen_d = req_gen;
                        state_d    = PEND;
                        sel_busy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                sel_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_gen_q  <= GEN2;
            pend_gen_q <= GEN2;
            sel_ack_q  <= 1'b0;
            sel_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_gen_q  <= cur_gen_d;
            pend_gen_q <= pend_gen_d;
            sel_ack_q  <= sel_ack_d;
            sel_busy_q <= sel_busy_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        phase_acc #(
            .ACC_W (ACC_W)
        ) u_lane_acc (
            .clk   (local_clk),
            .rst_n (rst),
            .inc   (lane_inc_w),
            .clear (apply_now),
            .hold  (lane_disable[i]),
            .stb   (lane_stb[i])
        );
    end

    phase_acc #(
        .ACC_W (ACC_W)
    ) u_fsm_acc (
        .clk   (local_clk),
        .rst_n (rst),
        .inc   (fsm_inc_w),
        .clear (apply_now),
        .hold  (1'b0),
        .stb   (fsm_stb_w)
    );

    assign fsm_stb  = fsm_stb_w;
    assign sel_ack  = sel_ack_q;
    assign sel_busy = sel_busy_q;
    assign cur_gen  = cur_gen_q;

endmodule

// File: tb/tb_lane_clk_enable_gen.sv
// Scoreboard bench for lane_clk_enable_gen: a cycle model queues expected outputs,
// and rate/latency windows are checked against the nominal strobe periods.
module tb_lane_clk_enable_gen;

    localparam int             NUM_CH  = 2;
    localparam int             ACC_W   = 24;
    localparam longint unsigned MODULUS = 64'd1 << ACC_W;

    logic              local_clk = 1'b0;
    logic              rst;
    logic [1:0]        gen_sel;
    logic              sel_req;
    logic              sel_ack;
    logic              sel_busy;
    logic [NUM_CH-1:0] lane_disable;
`ifdef PROG_INC_EN
    logic [ACC_W-1:0]  prog_inc;
`endif
    logic [NUM_CH-1:0] lane_stb;
    logic              fsm_stb;
    logic [1:0]        cur_gen;

    always #5 local_clk = ~local_clk;

    lane_clk_enable_gen #(
        .NUM_CH (NUM_CH),
        .ACC_W  (ACC_W)
    ) u_dut (
        .local_clk    (local_clk),
        .rst          (rst),
        .gen_sel      (gen_sel),
        .sel_req      (sel_req),
        .sel_ack      (sel_ack),
        .sel_busy     (sel_busy),
        .lane_disable (lane_disable),
`ifdef PROG_INC_EN
        .prog_inc     (prog_inc),
`endif
        .lane_stb     (lane_stb),
        .fsm_stb      (fsm_stb),
        .cur_gen      (cur_gen)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] lane;
        logic              fsm;
        logic              ack;
        logic              busy;
        logic [1:0]        cur;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // Observation counters, restarted per test window.
    int step_no, cnt_lane0, cnt_lane1, cnt_fsm, cnt_ack;
    int first_lane0, first_lane1, last_lane0;
    bit obs_fsm_cur, obs_fsm_prev;

    // Reference model state.
    int              m_state;
    int              m_cur, m_pend;
    longint unsigned m_acc [NUM_CH+1];
    bit              m_stb [NUM_CH+1];
    bit              m_ack, m_busy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic longint unsigned model_lane_inc(input int g);
        case (g)
            0: return 64'd2097152;
            1: return 64'd4194304;
            2: return 64'd8388608;
`ifdef PROG_INC_EN
            default: return {40'd0, prog_inc};
`else
            default: return 64'd8388608;
`endif
        endcase
    endfunction

    function automatic longint unsigned model_fsm_inc(input int g);
        case (g)
            0: return 64'd2033603;
            1: return 64'd4067206;
            2: return 64'd8388608;
`ifdef PROG_INC_EN
            default: return {40'd0, prog_inc};
`else
            default: return 64'd8388608;
`endif
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cur   = 0;
        m_pend  = 0;
        m_ack   = 1'b0;
        m_busy  = 1'b0;
        for (int ch = 0; ch <= NUM_CH; ch++) begin
            m_acc[ch] = 0;
            m_stb[ch] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs as driven now; queue the outputs.
    task automatic model_advance();
        exp_t            e;
        longint unsigned linc, finc, inc, s;
        bit              apply, hold;
        int              req;
        if (rst !== 1'b1) begin
            model_reset();
        end else begin
            linc  = model_lane_inc(m_cur);
            finc  = model_fsm_inc(m_cur);
            apply = (m_state == 1) && (m_stb[NUM_CH] || finc == 0);
`ifdef PROG_INC_EN
            req = int'(gen_sel);
`else
            req = (gen_sel == 2'd3) ? 2 : int'(gen_sel);
`endif
            if (m_state == 1) begin
                m_ack = 1'b0;
                if (apply) begin
                    m_state = 2;
                    m_cur   = m_pend;
                    m_ack   = 1'b1;
                    m_busy  = 1'b0;
                end
            end else begin
                m_state = 0;
                m_ack   = 1'b0;
                m_busy  = 1'b0;
                if (sel_req === 1'b1) begin
                    if (req == m_cur) begin
                        m_ack = 1'b1;
                    end else begin
                        m_pend  = req;
                        m_state = 1;
                        m_busy  = 1'b1;
                    end
                end
            end
            for (int ch = 0; ch <= NUM_CH; ch++) begin
                inc  = (ch < NUM_CH) ? linc : finc;
                hold = (ch < NUM_CH) ? (lane_disable[ch] === 1'b1) : 1'b0;
                if (apply || hold) begin
                    m_acc[ch] = 0;
                    m_stb[ch] = 1'b0;
                end else begin
                    s         = m_acc[ch] + inc;
                    m_stb[ch] = (s >= MODULUS);
                    m_acc[ch] = s % MODULUS;
                end
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) e.lane[ch] = m_stb[ch];
        e.fsm  = m_stb[NUM_CH];
        e.ack  = m_ack;
        e.busy = m_busy;
        e.cur  = m_cur[1:0];
        exp_q.push_back(e);
    endtask

    task automatic clear_counts();
        step_no     = 0;
        cnt_lane0   = 0;
        cnt_lane1   = 0;
        cnt_fsm     = 0;
        cnt_ack     = 0;
        first_lane0 = -1;
        first_lane1 = -1;
        last_lane0  = -1;
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("lane_stb", 32'(lane_stb), 32'(e.lane));
        check("fsm_stb",  32'(fsm_stb),  32'(e.fsm));
        check("sel_ack",  32'(sel_ack),  32'(e.ack));
        check("sel_busy", 32'(sel_busy), 32'(e.busy));
        check("cur_gen",  32'(cur_gen),  32'(e.cur));
        step_no++;
        if (lane_stb[0] === 1'b1) begin
            cnt_lane0++;
            if (first_lane0 < 0) first_lane0 = step_no;
            last_lane0 = step_no;
        end
        if (lane_stb[1] === 1'b1) begin
            cnt_lane1++;
            if (first_lane1 < 0) first_lane1 = step_no;
        end
        if (fsm_stb === 1'b1) cnt_fsm++;
        if (sel_ack === 1'b1) cnt_ack++;
        obs_fsm_prev = obs_fsm_cur;
        obs_fsm_cur  = (fsm_stb === 1'b1);
    endtask

    task automatic step();
        model_advance();
        @(posedge local_clk);
        #1;
        compare_out();
    endtask

    // Request a mode change and follow it to its sel_ack; requests made while busy must be ignored.
    task automatic change_gen(input logic [1:0] g, input logic [1:0] exp_cur, output int pend_cycles);
        int guard;
        guard       = 0;
        pend_cycles = 0;
        gen_sel     = g;
        sel_req     = 1'b1;
        step();
        check("req_busy", 32'(sel_busy), 1);
        while (sel_ack !== 1'b1 && guard < 64) begin
            sel_req = (sel_busy === 1'b1);
            gen_sel = g ^ 2'b01;
            step();
            guard++;
            pend_cycles++;
        end
        sel_req = 1'b0;
        gen_sel = g;
        if (guard >= 64) check("ack_timeout", 0, 1);
        check("apply_lane_quiet", 32'(lane_stb), 0);
        check("apply_fsm_quiet",  32'(fsm_stb), 0);
        check("apply_busy_low",   32'(sel_busy), 0);
        check("apply_cur_gen",    32'(cur_gen), 32'(exp_cur));
        check("apply_after_fsm",  32'(obs_fsm_prev), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend;
        rst          = 1'b1;
        gen_sel      = 2'd0;
        sel_req      = 1'b0;
        lane_disable = '0;
`ifdef PROG_INC_EN
        prog_inc     = '0;
`endif
        obs_fsm_cur  = 1'b0;
        obs_fsm_prev = 1'b0;
        model_reset();
        clear_counts();

        // Asynchronous reset state.
        #2 rst = 1'b0;
        #1;
        check("rst_lane_stb", 32'(lane_stb), 0);
        check("rst_fsm_stb",  32'(fsm_stb), 0);
        check("rst_sel_ack",  32'(sel_ack), 0);
        check("rst_sel_busy", 32'(sel_busy), 0);
        check("rst_cur_gen",  32'(cur_gen), 0);
        repeat (3) step();

        // Gen2 after reset release: lane every 8 cycles, 32 fsm strobes in 264 cycles.
        rst = 1'b1;
        clear_counts();
        repeat (264) step();
        check("gen2_first_lane0", first_lane0, 8);
        check("gen2_lane0_264",   cnt_lane0, 33);
        check("gen2_lane1_264",   cnt_lane1, 33);
        check("gen2_fsm_264",     cnt_fsm, 32);

        // Same-mode request: ack next cycle, strobe phase untouched.
        gen_sel = 2'd0;
        sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        check("same_ack",  32'(sel_ack), 1);
        check("same_busy", 32'(sel_busy), 0);
        repeat (15) step();
        check("same_phase", last_lane0 % 8, 0);
        check("same_lane0_count", cnt_lane0, 35);

        // Switch to Gen4: lane and fsm every 2 cycles after APPLY.
        change_gen(2'd2, 2'd2, pend);
        check("gen4_pend_max", 32'(pend <= 9), 1);
        clear_counts();
        repeat (20) step();
        check("gen4_first_lane0", first_lane0, 2);
        check("gen4_lane0_20",    cnt_lane0, 10);
        check("gen4_lane1_20",    cnt_lane1, 10);
        check("gen4_fsm_20",      cnt_fsm, 10);
        check("gen4_cur_gen",     32'(cur_gen), 2);

        // Gen3 with lane 1 disabled for 50 cycles.
        change_gen(2'd1, 2'd1, pend);
        check("gen3_pend_max", 32'(pend <= 2), 1);
        lane_disable = 2'b10;
        clear_counts();
        repeat (50) step();
        check("dis_lane1_quiet", cnt_lane1, 0);
        check("dis_lane0_50",    cnt_lane0, 12);
        check("dis_first_lane0", first_lane0, 4);
        check("dis_fsm_50",      cnt_fsm, 12);
        lane_disable = 2'b00;
        clear_counts();
        repeat (12) step();
        check("rel_first_lane1", first_lane1, 4);
        check("rel_lane1_12",    cnt_lane1, 3);

`ifdef PROG_INC_EN
        // Programmable mode: one lane strobe per 3 cycles.
        prog_inc = 24'd5592405;
        change_gen(2'd3, 2'd3, pend);
        clear_counts();
        repeat (3000) step();
        check("prog_lane0_3000", 32'(cnt_lane0 >= 999 && cnt_lane0 <= 1001), 1);
        check("prog_lane1_3000", 32'(cnt_lane1 >= 999 && cnt_lane1 <= 1001), 1);
`else
        // gen_sel=3 without the programmable option selects Gen4.
        change_gen(2'd3, 2'd2, pend);
        clear_counts();
        repeat (20) step();
        check("sel3_lane0_20", cnt_lane0, 10);
        check("sel3_cur_gen",  32'(cur_gen), 2);
`endif

        // Reset while a request is pending: everything clears, no ack afterwards.
        gen_sel = 2'd1;
        sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        check("pend_busy", 32'(sel_busy), 1);
        rst = 1'b0;
        #1;
        check("prst_lane_stb", 32'(lane_stb), 0);
        check("prst_fsm_stb",  32'(fsm_stb), 0);
        check("prst_sel_ack",  32'(sel_ack), 0);
        check("prst_sel_busy", 32'(sel_busy), 0);
        check("prst_cur_gen",  32'(cur_gen), 0);
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        clear_counts();
        repeat (24) step();
        check("prst_no_ack",      cnt_ack, 0);
        check("prst_first_lane0", first_lane0, 8);
        check("prst_lane0_24",    cnt_lane0, 3);
        check("prst_cur_gen_end", 32'(cur_gen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
